// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle execute unit.
// Holds the 4-bit ALU operation codes (same values the ALU control decoder
// drives), the execute FSM state encoding and a small opcode helper.
package alu_pkg;

  localparam int ALU_CODE_W = 4;

  localparam logic [ALU_CODE_W-1:0] ALU_AND  = 4'b0000;
  localparam logic [ALU_CODE_W-1:0] ALU_OR   = 4'b0001;
  localparam logic [ALU_CODE_W-1:0] ALU_ADD  = 4'b0010;
  localparam logic [ALU_CODE_W-1:0] ALU_XOR  = 4'b0011;
  localparam logic [ALU_CODE_W-1:0] ALU_SLL  = 4'b0100;
  localparam logic [ALU_CODE_W-1:0] ALU_SRL  = 4'b0101;
  localparam logic [ALU_CODE_W-1:0] ALU_SUB  = 4'b0110;
  localparam logic [ALU_CODE_W-1:0] ALU_SLT  = 4'b0111;
  localparam logic [ALU_CODE_W-1:0] ALU_SRA  = 4'b1000;
  localparam logic [ALU_CODE_W-1:0] ALU_SLTU = 4'b1001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  // True for the three opcodes that are executed iteratively.
  function automatic logic is_shift_op(input logic [ALU_CODE_W-1:0] code);
    logic r;
    case (code)
      ALU_SLL, ALU_SRL, ALU_SRA: r = 1'b1;
      default:                   r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_comb_unit.sv
// Single-cycle ALU datapath.
// Ports:
//   code    - 4-bit ALU operation code
//   a, b    - operands
//   res     - single-cycle result (shift codes return a unchanged; that is
//             the shamt = 0 answer, non-zero shifts are done iteratively)
//   illegal - code is not one of the defined operations
module alu_comb_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [ALU_CODE_W-1:0] code,
  input  logic [WIDTH-1:0]      a,
  input  logic [WIDTH-1:0]      b,
  output logic [WIDTH-1:0]      res,
  output logic                  illegal
);

  logic lt_signed;
  logic lt_unsigned;

  assign lt_signed   = ($signed(a) < $signed(b));
  assign lt_unsigned = (a < b);

  // Operation select; undefined codes fall back to ADD and raise illegal.
  always_comb begin
    res     = a + b;
    illegal = 1'b0;
    case (code)
      ALU_AND:  res = a & b;
      ALU_OR:   res = a | b;
      ALU_ADD:  res = a + b;
      ALU_XOR:  res = a ^ b;
      ALU_SUB:  res = a - b;
      ALU_SLT:  res = {{(WIDTH-1){1'b0}}, lt_signed};
      ALU_SLTU: res = {{(WIDTH-1){1'b0}}, lt_unsigned};
      ALU_SLL, ALU_SRL, ALU_SRA: res = a;
      default: begin
        res     = a + b;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle execute unit.
// One operation at a time via valid/ready; logic/arith/compare ops finish in
// one cycle, shifts run one bit per cycle. Result, zero and illegal_op are
// returned through a valid/ready output handshake.
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   in_valid / in_ready   - request handshake (in_ready = unit idle)
//   alu_control           - operation code
//   operand_a / operand_b - operands; operand_b[SHAMT_W-1:0] is the shamt
//   out_valid / out_ready - result handshake
//   result, zero          - registered result and its zero flag
//   illegal_op            - undefined opcode, registered with result
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ALU_CODE_W-1:0] alu_control,
  input  logic [WIDTH-1:0]      operand_a,
  input  logic [WIDTH-1:0]      operand_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      result,
  output logic                  zero,
  output logic                  illegal_op
);

  localparam int SHAMT_W = $clog2(WIDTH);
  localparam logic [SHAMT_W-1:0] CNT_ONE = SHAMT_W'(1);

  state_t                state_r,  state_s;
  logic [WIDTH-1:0]      acc_r,    acc_s;
  logic [SHAMT_W-1:0]    cnt_r,    cnt_s;
  logic [ALU_CODE_W-1:0] op_r,     op_s;
  logic [WIDTH-1:0]      result_r, result_s;
  logic                  ill_r,    ill_s;

  logic [WIDTH-1:0]   comb_res_s;
  logic               comb_ill_s;
  logic [WIDTH-1:0]   step_s;
  logic [SHAMT_W-1:0] shamt_in_s;

  assign shamt_in_s = operand_b[SHAMT_W-1:0];

  alu_comb_unit #(.WIDTH(WIDTH)) u_comb (
    .code    (alu_control),
    .a       (operand_a),
    .b       (operand_b),
    .res     (comb_res_s),
    .illegal (comb_ill_s)
  );

  // One-bit shift of the accumulator according to the latched opcode.
  always_comb begin
    step_s = acc_r;
    case (op_r)
      ALU_SLL: step_s = {acc_r[WIDTH-2:0], 1'b0};
      ALU_SRL: step_s = {1'b0, acc_r[WIDTH-1:1]};
      ALU_SRA: step_s = {acc_r[WIDTH-1], acc_r[WIDTH-1:1]};
      default: step_s = acc_r;
    endcase
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_s  = state_r;
    acc_s    = acc_r;
    cnt_s    = cnt_r;
    op_s     = op_r;
    result_s = result_r;
    ill_s    = ill_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          if (is_shift_op(alu_control) && (shamt_in_s != '0)) begin
            acc_s   = operand_a;
            cnt_s   = shamt_in_s;
            op_s    = alu_control;
            state_s = ST_SHIFT;
          end else begin
            result_s = comb_res_s;
            ill_s    = comb_ill_s;
            state_s  = ST_DONE;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        acc_s = step_s;
        cnt_s = cnt_r - CNT_ONE;
        // The step taken with cnt = 1 is the last one; its value is the answer.
        if (cnt_r == CNT_ONE) begin
          result_s = step_s;
          ill_s    = 1'b0;
          state_s  = ST_DONE;
        end else begin
          state_s = ST_SHIFT;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      acc_r    <= '0;
      cnt_r    <= '0;
      op_r     <= '0;
      result_r <= '0;
      ill_r    <= 1'b0;
    end else begin
      state_r  <= state_s;
      acc_r    <= acc_s;
      cnt_r    <= cnt_s;
      op_r     <= op_s;
      result_r <= result_s;
      ill_r    <= ill_s;
    end
  end

  assign in_ready   = (state_r == ST_IDLE);
  assign out_valid  = (state_r == ST_DONE);
  assign result     = result_r;
  assign zero       = (result_r == '0);
  assign illegal_op = ill_r;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed steps followed by randomized
// operations checked against a behavioural reference model.
module tb_seq_alu;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   alu_control;
  logic [W-1:0] operand_a;
  logic [W-1:0] operand_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic         illegal_op;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_control (alu_control),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .zero        (zero),
    .illegal_op  (illegal_op)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference result from the opcode table, using plain arithmetic.
  function automatic logic [W-1:0] ref_res(input logic [3:0] code, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    int unsigned sh;
    logic signed [W-1:0] sa;
    sh = b % W;
    sa = a;
    case (code)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return a + b;
      4'd3:    return a ^ b;
      4'd4:    return a << sh;
      4'd5:    return a >> sh;
      4'd6:    return a - b;
      4'd7:    return (sa < $signed(b)) ? W'(1) : W'(0);
      4'd8:    return sa >>> sh;
      4'd9:    return (a < b) ? W'(1) : W'(0);
      default: return a + b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [3:0] code, input logic [W-1:0] b);
    if ((code == 4'd4 || code == 4'd5 || code == 4'd8) && (b % W) != 0) return int'(b % W) + 1;
    return 1;
  endfunction

  // Issue one op, measure latency, check outputs, then hold out_ready low
  // for 'hold' cycles before accepting the result.
  task automatic run_op(input string tag, input logic [3:0] code, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int hold);
    int lat;
    int k;
    logic [W-1:0] exp;
    exp = ref_res(code, a, b);
    k = 0;
    while (!in_ready && k < 100) begin
      @(posedge clk); #1; k++;
    end
    check($sformatf("%s_ready", tag), W'(in_ready), W'(1));
    in_valid = 1'b1; alu_control = code; operand_a = a; operand_b = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    alu_control = 4'($urandom); operand_a = $urandom; operand_b = $urandom;
    check($sformatf("%s_busy", tag), W'(in_ready), W'(0));
    lat = 1;
    while (!out_valid && lat <= W + 4) begin
      @(posedge clk); #1; lat++;
    end
    check($sformatf("%s_lat", tag), W'(lat), W'(ref_lat(code, b)));
    check($sformatf("%s_res", tag), result, exp);
    check($sformatf("%s_zero", tag), W'(zero), W'(exp == '0));
    check($sformatf("%s_ill", tag), W'(illegal_op), W'(code > 4'd9));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
    end
    if (hold > 0) check($sformatf("%s_held", tag), result, exp);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check($sformatf("%s_ovdrop", tag), W'(out_valid), W'(0));
  endtask

  initial begin : main
    logic seen;
    logic [3:0] rc;
    logic [W-1:0] ra, rb;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    alu_control = 4'd0; operand_a = '0; operand_b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_result", result, W'(0));
    check("rst_zero", W'(zero), W'(1));
    check("rst_ready", W'(in_ready), W'(1));
    check("rst_ovalid", W'(out_valid), W'(0));
    check("rst_ill", W'(illegal_op), W'(0));
    rst = 1'b0;

    run_op("add",  4'b0010, 32'h0000_0005, 32'hFFFF_FFFB, 0);
    run_op("slt",  4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, 0);
    run_op("sltu", 4'b1001, 32'hFFFF_FFFF, 32'h0000_0001, 0);
    run_op("sra",  4'b1000, 32'h8000_0000, 32'h0000_001F, 0);
    run_op("srl",  4'b0101, 32'h8000_0000, 32'h0000_001F, 0);
    run_op("ill",  4'b1100, 32'h0000_0003, 32'h0000_0004, 0);
    run_op("sub",  4'b0110, 32'h0000_0003, 32'h0000_0004, 0);
    run_op("sll3", 4'b0100, 32'h0000_0001, 32'h0000_0003, 1);

    // SLL with shamt = 0: one-cycle latency, then a 5-cycle stall with
    // in_valid pulses that must be ignored.
    in_valid = 1'b1; alu_control = 4'b0100;
    operand_a = 32'h0000_0001; operand_b = 32'h0000_0020;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("sll0_ovalid", W'(out_valid), W'(1));
    check("sll0_res", result, 32'h0000_0001);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; alu_control = 4'b0010;
      operand_a = 32'h1234_0000; operand_b = 32'h0000_5678;
      @(posedge clk); #1;
      check($sformatf("stall%0d_ov", i), W'(out_valid), W'(1));
      check($sformatf("stall%0d_res", i), result, 32'h0000_0001);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("stall_ready", W'(in_ready), W'(1));
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1; seen = seen | out_valid;
    end
    check("stall_noaccept", W'(seen), W'(0));

    // Reset during the 4th shift cycle of SLL by 10.
    in_valid = 1'b1; alu_control = 4'b0100;
    operand_a = 32'h0000_00FF; operand_b = 32'h0000_000A;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_ovalid", W'(out_valid), W'(0));
    check("abort_result", result, W'(0));
    check("abort_zero", W'(zero), W'(1));
    check("abort_ready", W'(in_ready), W'(1));
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1; seen = seen | out_valid;
    end
    check("abort_noov", W'(seen), W'(0));

    // Randomized operations against the reference model.
    for (int n = 0; n < 40; n++) begin
      rc = 4'($urandom_range(15, 0));
      ra = $urandom;
      rb = $urandom;
      if (n % 4 == 0) ra = ra | 32'h8000_0000;
      if (n % 5 == 0) rb = ra;
      run_op($sformatf("rnd%0d_op%0d", n, rc), rc, ra, rb, $urandom_range(3, 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
